// File: rtl/sint32_seq_adder_ctrl.sv
// Sequencer that builds a 32-bit add from three passes (LO, HI, FIX) through one
// registered 16-bit adder. Optional macro SINT32_SEQ_SKIP_FIX_EN drops FIX when c_lo==0.
module sint32_seq_adder_ctrl #(
  parameter int ADDER_LAT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_A,
  input  logic [31:0] in_B,
  output logic [15:0] add_A,
  output logic [15:0] add_B,
  input  logic [15:0] add_C,
  input  logic        add_Cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        out_cout,
  output logic        out_ovf
);

  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        a_hi_q, a_hi_d;
  logic [15:0]        b_hi_q, b_hi_d;
  logic [15:0]        add_a_q, add_a_d;
  logic [15:0]        add_b_q, add_b_d;
  logic [15:0]        lo_sum_q, lo_sum_d;
  logic               c_lo_q, c_lo_d;
  logic               c_hi_q, c_hi_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_sum_q, out_sum_d;
  logic               out_cout_q, out_cout_d;
  logic               out_ovf_q, out_ovf_d;

  logic               pass_done;
  logic               ovf_calc;

  // The adder result is sampled on the edge closing the (ADDER_LAT+1)th cycle of a pass.
  assign pass_done = (cnt_q == CNT_W'(ADDER_LAT));

  // Whichever pass produces the upper half, add_C is that half of the final sum.
  assign ovf_calc  = (a_hi_q[15] == b_hi_q[15]) && (add_C[15] != a_hi_q[15]);

  assign in_ready  = rstn && (state_q == S_IDLE);
  assign add_A     = add_a_q;
  assign add_B     = add_b_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_hi_q      <= '0;
      b_hi_q      <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      lo_sum_q    <= '0;
      c_lo_q      <= 1'b0;
      c_hi_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_hi_q      <= a_hi_d;
      b_hi_q      <= b_hi_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      lo_sum_q    <= lo_sum_d;
      c_lo_q      <= c_lo_d;
      c_hi_q      <= c_hi_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_hi_d      = a_hi_q;
    b_hi_d      = b_hi_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    lo_sum_d    = lo_sum_q;
    c_lo_d      = c_lo_q;
    c_hi_d      = c_hi_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (in_valid && in_ready) begin
          a_hi_d  = in_A[31:16];
          b_hi_d  = in_B[31:16];
          add_a_d = in_A[15:0];
          add_b_d = in_B[15:0];
          state_d = S_LO;
        end
      end

      S_LO: begin
        cnt_d = cnt_q + 1'b1;
        if (pass_done) begin
          lo_sum_d = add_C;
          c_lo_d   = add_Cout;
          add_a_d  = a_hi_q;
          add_b_d  = b_hi_q;
          cnt_d    = '0;
          state_d  = S_HI;
        end
      end

      S_HI: begin
        cnt_d = cnt_q + 1'b1;
        if (pass_done) begin
          c_hi_d = add_Cout;
          cnt_d  = '0;
`ifdef SINT32_SEQ_SKIP_FIX_EN
          if (!c_lo_q) begin
            out_sum_d   = {add_C, lo_sum_q};
            out_cout_d  = add_Cout;
            out_ovf_d   = ovf_calc;
            out_valid_d = 1'b1;
            add_a_d     = '0;
            add_b_d     = '0;
            state_d     = S_DONE;
          end else begin
            add_a_d = add_C;
            add_b_d = {15'b0, c_lo_q};
            state_d = S_FIX;
          end
`else
          // Propagate the low-half carry into the upper half with a second pass.
          add_a_d = add_C;
          add_b_d = {15'b0, c_lo_q};
          state_d = S_FIX;
`endif
        end
      end

      S_FIX: begin
        cnt_d = cnt_q + 1'b1;
        if (pass_done) begin
          out_sum_d   = {add_C, lo_sum_q};
          // HI and FIX carries are mutually exclusive, so OR is the true carry.
          out_cout_d  = c_hi_q | add_Cout;
          out_ovf_d   = ovf_calc;
          out_valid_d = 1'b1;
          add_a_d     = '0;
          add_b_d     = '0;
          cnt_d       = '0;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        cnt_d = '0;
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sint32_seq_adder_ctrl.sv
// Bench for sint32_seq_adder_ctrl: directed vector table, back-pressure and reset
// sequences, then randomized operands checked against a plain-arithmetic model.
module tb_sint32_seq_adder_ctrl;

  localparam int LAT = 1;
  localparam int P   = LAT + 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_A = '0;
  logic [31:0] in_B = '0;
  logic [15:0] add_A, add_B;
  logic [15:0] add_C;
  logic        add_Cout;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic        out_cout, out_ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Behavioural 16-bit adder with LAT registered stages and no reset.
  logic [16:0] pipe [LAT];
  initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
  always @(posedge clk) begin
    pipe[0] <= {1'b0, add_A} + {1'b0, add_B};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign add_C    = pipe[LAT-1][15:0];
  assign add_Cout = pipe[LAT-1][16];

  sint32_seq_adder_ctrl #(.ADDER_LAT(LAT)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_A(in_A), .in_B(in_B),
    .add_A(add_A), .add_B(add_B), .add_C(add_C), .add_Cout(add_Cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: 32-bit sum from plain wide arithmetic.
  function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] s, output logic c,
                                  output logic o, output int passes);
    logic [32:0] u;
    longint      ss;
    u  = {1'b0, a} + {1'b0, b};
    ss = longint'($signed(a)) + longint'($signed(b));
    s  = u[31:0];
    c  = u[32];
    o  = (ss > 64'sh7FFF_FFFF) || (ss < -64'sh8000_0000);
`ifdef SINT32_SEQ_SKIP_FIX_EN
    passes = ((32'(a[15:0]) + 32'(b[15:0])) > 32'hFFFF) ? 3 : 2;
`else
    passes = 3;
`endif
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] es, input logic ec, input logic eo,
                       input int passes, input int stall, input bit offer,
                       input logic [31:0] na, input logic [31:0] nb);
    int          edges;
    int          guard;
    logic [31:0] lo_c;
    lo_c     = ((32'(a[15:0]) + 32'(b[15:0])) > 32'hFFFF) ? 32'd1 : 32'd0;
    in_A     = a;
    in_B     = b;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("accept_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges    = 0;
    chk("pass_lo_A", {16'b0, add_A}, {16'b0, a[15:0]});
    chk("pass_lo_B", {16'b0, add_B}, {16'b0, b[15:0]});
    chk("busy_ready", {31'b0, in_ready}, 32'd0);
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (edges == P) begin
        chk("pass_hi_A", {16'b0, add_A}, {16'b0, a[31:16]});
        chk("pass_hi_B", {16'b0, add_B}, {16'b0, b[31:16]});
      end
      if (edges == 2 * P && passes == 3) begin
        chk("pass_fix_A", {16'b0, add_A}, {16'b0, a[31:16] + b[31:16]});
        chk("pass_fix_B", {16'b0, add_B}, lo_c);
      end
    end
    chk("latency", edges, passes * P);
    chk("sum", out_sum, es);
    chk("cout", {31'b0, out_cout}, {31'b0, ec});
    chk("ovf", {31'b0, out_ovf}, {31'b0, eo});
    chk("done_addA", {16'b0, add_A}, 32'd0);
    if (offer) begin
      in_A     = na;
      in_B     = nb;
      in_valid = 1'b1;
    end
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_sum", out_sum, es);
      chk("hold_ready", {31'b0, in_ready}, 32'd0);
      chk("hold_noaccept", {16'b0, add_A}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_valid", {31'b0, out_valid}, 32'd0);
    chk("post_sum_kept", out_sum, es);
    chk("post_ready", {31'b0, in_ready}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          passes_skip;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] ra, rb, rs;
    logic        rc, ro;
    int          rp, np;

    vecs[0] = '{32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 3};
    vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 3};
    vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 3};
    vecs[3] = '{32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 2};
    vecs[4] = '{32'h00010002, 32'h00030004, 32'h00040006, 1'b0, 1'b0, 2};
    vecs[5] = '{32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 2};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0, 3};
    vecs[7] = '{32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 2};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_addA", {16'b0, add_A}, 32'd0);
    chk("rst_addB", {16'b0, add_B}, 32'd0);
    chk("rst_sum", out_sum, 32'd0);
    chk("rst_flags", {30'b0, out_cout, out_ovf}, 32'd0);
    rstn = 1'b1;
    #1;
    chk("idle_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
`ifdef SINT32_SEQ_SKIP_FIX_EN
      np = vecs[i].passes_skip;
`else
      np = 3;
`endif
      do_op(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout, vecs[i].ovf,
            np, i % 3, 1'b0, 32'h0, 32'h0);
      $display("vec %0d: %08h + %08h -> %08h c=%0b v=%0b", i, vecs[i].a, vecs[i].b,
               out_sum, out_cout, out_ovf);
    end

    // Back-pressure with a new pair offered while the result is pending
    do_op(32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 3, 5, 1'b1,
          32'h12345678, 32'h11111111);
    chk("bp_offer_held", {31'b0, in_valid}, 32'd1);
    do_op(32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0,
`ifdef SINT32_SEQ_SKIP_FIX_EN
          2,
`else
          3,
`endif
          0, 1'b0, 32'h0, 32'h0);
    $display("backpressure: next pair result %08h", out_sum);

    // Reset during the HI pass
    in_A     = 32'hABCD1234;
    in_B     = 32'h5678FFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (P) @(posedge clk);
    #3;
    chk("midrst_inHI", {16'b0, add_A}, 32'h0000ABCD);
    rstn = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_ready", {31'b0, in_ready}, 32'd0);
    chk("midrst_addA", {16'b0, add_A}, 32'd0);
    chk("midrst_addB", {16'b0, add_B}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    chk("midrst_idle", {31'b0, in_ready}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("midrst_noemit", {31'b0, out_valid}, 32'd0);
    end
    do_op(32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0,
`ifdef SINT32_SEQ_SKIP_FIX_EN
          2,
`else
          3,
`endif
          1, 1'b0, 32'h0, 32'h0);
    $display("after reset: 2 + 3 -> %08h", out_sum);

    // Randomized operands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra[15:0] = 16'hFFFF;
      if ($urandom_range(0, 3) == 0) rb[31:16] = 16'h7FFF;
      if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
      ref_add(ra, rb, rs, rc, ro, rp);
      do_op(ra, rb, rs, rc, ro, rp, int'($urandom_range(0, 3)), 1'b0, 32'h0, 32'h0);
      $display("rand %0d: %08h + %08h -> %08h c=%0b v=%0b", i, ra, rb, out_sum,
               out_cout, out_ovf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sint32_seq_adder_ctrl.md
Name: sint32_seq_adder_ctrl

Overview:
- Sequencing stage wrapped around the registered 16-bit signed/unsigned adder: Sint16_adder, 1-cycle registered result, no carry-in.
- Accepts 32-bit operand pairs over a valid/ready handshake and splits each into 16-bit halves.
- Drives the adder's data_A/data_B, consumes its data_C/Cout, and assembles a 32-bit sum with carry-out and signed overflow.
- Lets the sint32 datapath reuse one 16-bit adder instead of a full 32-bit carry chain.

Parameters:
- ADDER_LAT, 1, adder result latency in clock edges (legal 1..4); each adder pass lasts ADDER_LAT+1 cycles.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- in_A  in  32  operand A
- in_B  in  32  operand B
- add_A  out  16  to adder data_A
- add_B  out  16  to adder data_B
- add_C  in  16  from adder data_C
- add_Cout  in  1  from adder Cout
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  32  A+B modulo 2^32
- out_cout  out  1  unsigned carry out of bit 31
- out_ovf  out  1  signed two's-complement overflow

Behaviour:
Reset:
- All outputs and state registers are async-cleared when rstn is low: state=IDLE, add_A/add_B=0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
- in_ready=0 while rstn is low, then 1 in IDLE.
- Reset mid-operation abandons the operation; nothing is emitted.

States: IDLE, LO, HI, FIX, DONE.
- in_ready = (state==IDLE). No overlap: a new operand pair is never accepted while an operation or result is pending.

IDLE:
- On in_valid&&in_ready: latch in_A/in_B, load add_A=A[15:0], add_B=B[15:0], go to LO.

Pass timing (LO/HI/FIX):
- add_A/add_B are registered and held stable for the whole pass.
- A pass counter clears on entry to each pass.
- add_C/add_Cout are captured on the edge that ends the pass's (ADDER_LAT+1)th cycle.

LO:
- Capture lo_sum=add_C, c_lo=add_Cout.
- Load add_A=A[31:16], add_B=B[31:16], go to HI.

HI:
- Capture hi_sum, c_hi.
- Load add_A=hi_sum, add_B={15'b0,c_lo}, go to FIX.

FIX:
- Capture fix_sum, c_fix.
- out_sum={fix_sum,lo_sum}, out_cout=c_hi|c_fix (at most one can be set), out_ovf=(A[31]==B[31])&&(out_sum[31]!=A[31]).
- Drive add_A/add_B to 0, set out_valid=1, go to DONE.

DONE:
- out_valid, out_sum, out_cout and out_ovf are held stable until out_valid&&out_ready.
- On that edge: out_valid=0, go to IDLE.
- out_sum/out_cout/out_ovf keep their last values in IDLE.

Latency and throughput:
- Accept edge to out_valid rising = 3*(ADDER_LAT+1) edges, which is 6 for the default.
- Best-case throughput is one result per 3*(ADDER_LAT+1)+2 cycles.

Boundary conditions:
- in_valid is ignored outside IDLE.
- add_C/add_Cout are ignored except on capture edges.
- Wrap-around is modulo 2^32; carry is reported only via out_cout.

Optional Feature:
- Macro SINT32_SEQ_SKIP_FIX_EN.
- Defined: if c_lo==0 at the end of LO, FIX is skipped. HI then produces out_sum={hi_sum,lo_sum}, out_cout=c_hi and the same overflow rule, and goes straight to DONE. Latency is 2*(ADDER_LAT+1) when c_lo==0, otherwise 3*(ADDER_LAT+1).
- Not defined: FIX always runs, adding 0 when c_lo==0, giving a constant latency of 3*(ADDER_LAT+1).

Test Plan:
1. A=0x0000FFFF, B=0x00000001, ADDER_LAT=1 -> out_sum=0x00010000, out_cout=0, out_ovf=0; out_valid rises 6 edges after the accept edge; the adder sees 0xFFFF+0x0001, then 0x0000+0x0000, then 0x0000+0x0001.
2. A=0x7FFFFFFF, B=0x00000001 -> out_sum=0x80000000, out_cout=0, out_ovf=1.
3. A=0xFFFFFFFF, B=0x00000001 -> out_sum=0x00000000, out_cout=1 (from the FIX pass), out_ovf=0. A=0x80000000, B=0x80000000 -> out_sum=0x00000000, out_cout=1 (from the HI pass), out_ovf=1.
4. Hold out_ready=0 for 5 cycles after out_valid rises, with in_valid=1 and a new pair offered -> out_valid and the result stay stable, in_ready=0, the new pair is not accepted; it is accepted in the IDLE cycle after the out handshake.
5. Drive rstn low during the HI pass -> immediately: out_valid=0, in_ready=0, add_A=add_B=0. After release: IDLE with in_ready=1, and the next operation (0x00000002+0x00000003 -> 0x00000005) completes correctly.
6. With SINT32_SEQ_SKIP_FIX_EN defined: A=0x00010002, B=0x00030004 -> out_sum=0x00040006 with out_valid 4 edges after accept; A=0x0000FFFF, B=0x00000001 still takes 6 edges.
